// File: rtl/keypad_loader.sv
// Keypad digit loader: synchronizes and debounces a 10-key pad, then strobes each accepted digit into a BCD timer.
// Optional macro KEYPAD_DIGIT_LIMIT_EN caps entry at three digits and raises full.
module keypad_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] keys,
  input  logic       enable,
  input  logic       restart,
  output logic [3:0] bcd_output,
  output logic       loadn,
  output logic [1:0] digit_count,
  output logic       full
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, LOAD, WAIT_RELEASE} state_t;

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  state_t     state_q, state_d;
  logic [9:0] sync1_q, sync1_d;
  logic [9:0] sync_keys_q, sync_keys_d;
  logic [9:0] cap_q, cap_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] bcd_q, bcd_d;
  logic       loadn_q, loadn_d;
  logic [1:0] count_q, count_d;
  logic       entry_full;

  function automatic logic is_one_hot(input logic [9:0] k);
    is_one_hot = (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] key_index(input logic [9:0] k);
    key_index = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) key_index = 4'(i);
    end
  endfunction

  always_comb begin
    sync1_d     = keys;
    sync_keys_d = sync1_q;
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (clear) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync_keys_q <= '0;
      cap_q       <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      loadn_q     <= 1'b1;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync_keys_q <= sync_keys_d;
      cap_q       <= cap_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      loadn_q     <= loadn_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic; the stable counter serves both press and release debouncing.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which would infer a latch.
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable && !entry_full && is_one_hot(sync_keys_q)) begin
          state_d = DEBOUNCE;
          cap_d   = sync_keys_q;
          cnt_d   = '0;
        end else if (sync_keys_q != 10'd0) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      DEBOUNCE: begin
        if (!enable) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end else if (sync_keys_q != cap_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == DB_LIMIT) begin
            state_d = LOAD;
            cnt_d   = '0;
          end
        end
      end
      LOAD: begin
        state_d = WAIT_RELEASE;
        cnt_d   = '0;
      end
      WAIT_RELEASE: begin
        if (sync_keys_q == 10'd0) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == DB_LIMIT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so loadn is glitch-free and aligned with LOAD.
  always_comb begin
    loadn_d = (state_d != LOAD);
    bcd_d   = bcd_q;
    count_d = count_q;
    if (state_q == DEBOUNCE && state_d == LOAD) bcd_d = key_index(cap_q);
    if (restart) count_d = 2'd0;
    else if (state_q == LOAD) count_d = count_q + 2'd1;
  end

`ifdef KEYPAD_DIGIT_LIMIT_EN
  logic full_q, full_d;

  always_comb full_d = (count_d == 2'd3);

  always_ff @(posedge clk) begin
    if (clear) full_q <= 1'b0;
    else       full_q <= full_d;
  end

  assign entry_full = full_q;
  assign full       = full_q;
`else
  assign entry_full = 1'b0;
  assign full       = 1'b0;
`endif

  assign bcd_output  = bcd_q;
  assign loadn       = loadn_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_keypad_loader.sv
// Self-checking bench for keypad_loader: directed scenarios with literal expectations plus
// randomized key traffic compared every cycle against an event-level reference model.
module tb_keypad_loader;

  localparam int D = 4;
`ifdef KEYPAD_DIGIT_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [9:0] keys = '0;
  logic       enable = 1'b1;
  logic       restart = 1'b0;
  logic [3:0] bcd_output;
  logic       loadn;
  logic [1:0] digit_count;
  logic       full;

  keypad_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .clear(clear), .keys(keys), .enable(enable), .restart(restart),
    .bcd_output(bcd_output), .loadn(loadn), .digit_count(digit_count), .full(full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks the two-stage sampled key history, the candidate key being
  // qualified, a run length of agreeing samples, and whether a release must be seen.
  logic [9:0] m_sy1 = '0, m_sy2 = '0;
  bit m_wait = 0, m_loading = 0;
  int m_cand = -1, m_run = 0, m_bcd = 0, m_count = 0;

  task automatic model_step();
    logic [9:0] sk;
    bit full_now, inc;
    if (clear) begin
      m_sy1 = '0; m_sy2 = '0; m_wait = 0; m_loading = 0;
      m_cand = -1; m_run = 0; m_bcd = 0; m_count = 0;
      return;
    end
    sk = m_sy2;
    full_now = LIMIT && (m_count == 3);
    inc = 0;
    if (m_loading) begin
      m_loading = 0; m_wait = 1; m_run = 0; inc = 1;
    end else if (m_wait) begin
      if (sk == 0) begin
        m_run++;
        if (m_run == D) begin m_wait = 0; m_run = 0; end
      end else m_run = 0;
    end else if (m_cand >= 0) begin
      if (!enable) begin
        m_cand = -1; m_wait = 1; m_run = 0;
      end else if (sk != (10'b1 << m_cand)) begin
        m_cand = -1; m_run = 0;
      end else begin
        m_run++;
        if (m_run == D) begin m_bcd = m_cand; m_loading = 1; m_cand = -1; m_run = 0; end
      end
    end else if (sk != 0) begin
      if (enable && !full_now && $countones(sk) == 1) begin
        for (int i = 0; i < 10; i++) if (sk[i]) m_cand = i;
        m_run = 0;
      end else begin
        m_wait = 1; m_run = 0;
      end
    end
    if (restart) m_count = 0;
    else if (inc) m_count = (m_count + 1) % 4;
    m_sy2 = m_sy1;
    m_sy1 = keys;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (loadn === 1'b0) pulses++;
    if (chk_en) begin
      check("loadn", int'(loadn), int'(!m_loading));
      check("bcd_output", int'(bcd_output), m_bcd);
      check("digit_count", int'(digit_count), m_count);
      check("full", int'(full), int'(LIMIT && m_count == 3));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int hold);
    keys = 10'b1 << k;
    cycles(hold);
    keys = '0;
    cycles(D + 6);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    cycles(1);
  endtask

  int p0, lat;
  bit seen;

  initial begin
    cycles(2);
    clear = 1'b0;
    chk_en = 1'b1;
    check("reset_loadn", int'(loadn), 1);
    check("reset_bcd", int'(bcd_output), 0);
    check("reset_count", int'(digit_count), 0);
    check("reset_full", int'(full), 0);

    // Key 7 held: one pulse, (D+3) edges after the first sampling edge.
    p0 = pulses; lat = -1;
    keys = 10'b1 << 7;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (loadn === 1'b0 && lat < 0) lat = n;
    end
    keys = '0;
    cycles(D + 6);
    check("latency", lat, 7);
    check("k7_pulses", pulses - p0, 1);
    check("k7_bcd", int'(bcd_output), 7);
    check("k7_count", int'(digit_count), 1);

    // Sequence 1,2,0 then a fourth press of 5.
    do_clear();
    p0 = pulses;
    press(1, 10); check("seq_bcd1", int'(bcd_output), 1);
    press(2, 10); check("seq_bcd2", int'(bcd_output), 2);
    press(0, 10);
    check("seq_pulses", pulses - p0, 3);
    check("seq_bcd0", int'(bcd_output), 0);
    check("seq_count", int'(digit_count), 3);
    p0 = pulses;
    press(5, 10);
`ifdef KEYPAD_DIGIT_LIMIT_EN
    check("limit_pulses", pulses - p0, 0);
    check("limit_full", int'(full), 1);
    check("limit_count", int'(digit_count), 3);
`else
    check("wrap_pulses", pulses - p0, 1);
    check("wrap_bcd", int'(bcd_output), 5);
    check("wrap_count", int'(digit_count), 0);
`endif
    restart = 1'b1; cycles(1); restart = 1'b0;
    check("restart_count", int'(digit_count), 0);
    check("restart_full", int'(full), 0);

    // Bounce on key 3 never qualifies.
    p0 = pulses;
    keys = 10'b1 << 3; cycles(2);
    keys = '0;         cycles(2);
    keys = 10'b1 << 3; cycles(2);
    keys = '0;         cycles(D + 6);
    check("bounce_pulses", pulses - p0, 0);

    // Two keys together are rejected until released.
    p0 = pulses;
    keys = (10'b1 << 2) | (10'b1 << 6);
    cycles(12);
    keys = '0;
    cycles(D + 6);
    check("multi_pulses", pulses - p0, 0);
    press(6, 10);
    check("multi_then6_pulses", pulses - p0, 1);
    check("multi_then6_bcd", int'(bcd_output), 6);

    // Key held while disabled stays ignored after enable rises.
    p0 = pulses;
    enable = 1'b0; keys = 10'b1 << 4;
    cycles(5);
    enable = 1'b1;
    cycles(12);
    keys = '0;
    cycles(D + 6);
    check("disabled_pulses", pulses - p0, 0);
    press(4, 10);
    check("fresh4_pulses", pulses - p0, 1);
    check("fresh4_bcd", int'(bcd_output), 4);

    // Restart landing on the LOAD cycle: pulse still happens, count ends at 0.
    p0 = pulses; seen = 0;
    keys = 10'b1 << 8;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (loadn === 1'b0) seen = 1;
    end
    restart = 1'b1; cycles(1); restart = 1'b0;
    check("rl_seen", int'(seen), 1);
    check("rl_count", int'(digit_count), 0);
    keys = '0;
    cycles(D + 6);
    check("rl_pulses", pulses - p0, 1);
    check("rl_bcd", int'(bcd_output), 8);

    // Clear during debounce of key 9 aborts the load.
    p0 = pulses;
    keys = 10'b1 << 9;
    cycles(4);
    clear = 1'b1; keys = '0;
    cycles(1);
    clear = 1'b0;
    cycles(D + 6);
    check("clr_pulses", pulses - p0, 0);
    check("clr_loadn", int'(loadn), 1);
    check("clr_bcd", int'(bcd_output), 0);
    check("clr_count", int'(digit_count), 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 150; it++) begin
      int r, hold;
      logic [9:0] pat;
      r = $urandom_range(0, 9);
      if (r < 2)      pat = '0;
      else if (r < 8) pat = 10'b1 << $urandom_range(0, 9);
      else if (r < 9) pat = (10'b1 << $urandom_range(0, 9)) | (10'b1 << $urandom_range(0, 9));
      else            pat = 10'($urandom_range(0, 1023));
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        keys    = pat;
        enable  = ($urandom_range(0, 7) != 0);
        restart = ($urandom_range(0, 24) == 0);
        clear   = ($urandom_range(0, 199) == 0);
        cycles(1);
      end
    end
    keys = '0; enable = 1'b1; restart = 1'b0; clear = 1'b0;
    cycles(D + 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keypad_loader.md
KEYPAD_LOADER -- requirements
Module: keypad_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning: consecutive stable synchronized samples required to accept a press or a release (legal range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset, synchronous, active-high.
REQ-004 keys  input  10  raw asynchronous keypad lines; bit k high = digit key k pressed.
REQ-005 enable  input  1  high = entry allowed (timer idle); low = keys ignored.
REQ-006 restart  input  1  one-cycle pulse; starts a new entry by zeroing digit_count.
REQ-007 bcd_output  output  4  BCD digit presented to the timer bcd_input.
REQ-008 loadn  output  1  active-low one-cycle load strobe to the timer loadn.
REQ-009 digit_count  output  2  digits loaded since clear/restart.
REQ-010 full  output  1  entry full; meaningful only with KEYPAD_DIGIT_LIMIT_EN.

Function
REQ-011 keys SHALL pass through a 2-flop synchronizer before any use; sync_keys denotes its output.
REQ-012 FSM states SHALL be IDLE, DEBOUNCE, LOAD, WAIT_RELEASE.
REQ-013 IDLE: if enable=1, entry is not full, and sync_keys is one-hot, capture sync_keys and go to DEBOUNCE with the stable counter at 0.
REQ-014 IDLE: if sync_keys is nonzero but not one-hot, or enable=0 with any key set, go to WAIT_RELEASE.
REQ-015 DEBOUNCE: each cycle sync_keys equals the captured value, increment the stable counter; on reaching DEBOUNCE_CYCLES go to LOAD.
REQ-016 DEBOUNCE: any mismatch with the captured value SHALL return to IDLE with no load; enable=0 SHALL go to WAIT_RELEASE.
REQ-017 bcd_output SHALL be registered with the binary index of the captured key on the transition into LOAD and held until the next LOAD.
REQ-018 LOAD: loadn=0 for exactly one cycle with bcd_output stable in that cycle; digit_count increments (wrapping 3->0 when the limit is compiled out); next state is WAIT_RELEASE.
REQ-019 Latency: with keys held constant and enable=1, loadn SHALL be low in the cycle after the (DEBOUNCE_CYCLES+3)-th rising edge at which the key is sampled high, counting the first sampling edge as 1.
REQ-020 WAIT_RELEASE: return to IDLE only after sync_keys==0 for DEBOUNCE_CYCLES consecutive cycles; any nonzero sample restarts the count.
REQ-021 Exactly one loadn pulse SHALL occur per accepted press, regardless of hold time.
REQ-022 restart=1 SHALL zero digit_count and deassert full next cycle; if coincident with LOAD, loadn still pulses and digit_count ends at 0.
REQ-023 loadn SHALL be driven directly from a register (glitch-free).

Reset
REQ-024 clear=1 at a rising edge SHALL set state IDLE, loadn=1, bcd_output=0, digit_count=0, full=0, and zero the synchronizer and counters, overriding every other input including restart.
REQ-025 clear asserted mid-DEBOUNCE or mid-LOAD SHALL abort without emitting or completing a loadn pulse.

Configuration
REQ-026 Macro KEYPAD_DIGIT_LIMIT_EN defined: full=1 once digit_count reaches 3; IDLE then routes presses to WAIT_RELEASE without loading until restart or clear.
REQ-027 Macro KEYPAD_DIGIT_LIMIT_EN undefined: full is tied to 0, presses are unlimited, and older digits shift out of the timer.

Verification
REQ-028 DEBOUNCE_CYCLES=4, enable=1, keys=bit7 held 20 cycles -> single loadn low pulse 7 cycles after the first sampling edge, bcd_output=7, digit_count=1.
REQ-029 Keys 1,2,0 pressed and released in sequence -> three loadn pulses with bcd_output 1, 2, 0 and digit_count 3; with the limit enabled, a fourth press of key 5 -> no pulse, full=1.
REQ-030 keys=bit3 for 2 cycles, bounce to 0, then bit3 for 2 cycles -> no loadn pulse.
REQ-031 keys=bit2|bit6 held -> no pulse; after release and a press of key 6 -> one pulse with bcd_output=6.
REQ-032 enable=0 while key 4 held and enable raised mid-hold -> no pulse until release and a fresh press.
REQ-033 clear pulsed during DEBOUNCE of key 9 -> loadn stays 1, all outputs 0; restart with digit_count=3 -> digit_count=0, full=0.
